// File: rtl/onchip_mem_port_arbiter.sv
// Two-master round-robin Avalon-MM arbiter in front of one on-chip memory port.
// Bursts are expanded into single-word accesses; read data returns one cycle after issue.

module onchip_mem_port_arbiter_lane #(
  parameter int BURST_W = 5,
  parameter bit IDX     = 1'b0
) (
  input  logic               read,
  input  logic               write,
  input  logic [BURST_W-1:0] burstcount,
  input  logic               rd_vld,
  input  logic               rd_owner,
  output logic               req,
  output logic [BURST_W-1:0] extra,
  output logic               readdatavalid
);
  assign req           = read | write;
  // beats after the first; a zero burstcount behaves as a single beat
  assign extra         = (burstcount == '0) ? '0 : burstcount - BURST_W'(1);
  assign readdatavalid = rd_vld & (rd_owner == IDX);
endmodule

module onchip_mem_port_arbiter #(
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 64,
  parameter int BE_W    = 8,
  parameter int BURST_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  m0_address,
  input  logic               m0_read,
  input  logic               m0_write,
  input  logic [DATA_W-1:0]  m0_writedata,
  input  logic [BE_W-1:0]    m0_byteenable,
  input  logic [BURST_W-1:0] m0_burstcount,
  output logic               m0_waitrequest,
  output logic [DATA_W-1:0]  m0_readdata,
  output logic               m0_readdatavalid,
  input  logic [ADDR_W-1:0]  m1_address,
  input  logic               m1_read,
  input  logic               m1_write,
  input  logic [DATA_W-1:0]  m1_writedata,
  input  logic [BE_W-1:0]    m1_byteenable,
  input  logic [BURST_W-1:0] m1_burstcount,
  output logic               m1_waitrequest,
  output logic [DATA_W-1:0]  m1_readdata,
  output logic               m1_readdatavalid,
  output logic [ADDR_W-1:0]  mem_address,
  output logic               mem_chipselect,
  output logic               mem_write,
  output logic [DATA_W-1:0]  mem_writedata,
  output logic [BE_W-1:0]    mem_byteenable,
  input  logic [DATA_W-1:0]  mem_readdata
);
  typedef enum logic [1:0] {IDLE, RBURST, WBURST} state_t;

  state_t             state, state_nx;
  logic               rr_ptr, owner, rd_vld, rd_owner;
  logic               win, accept, step;
  logic [ADDR_W-1:0]  next_addr;
  logic [BURST_W-1:0] remaining;

  logic [1:0]               rd, wr, req, rdv, wait_n;
  logic [1:0][ADDR_W-1:0]   addr;
  logic [1:0][DATA_W-1:0]   wdata;
  logic [1:0][BE_W-1:0]     be;
  logic [1:0][BURST_W-1:0]  bc, extra;

  assign rd    = {m1_read, m0_read};
  assign wr    = {m1_write, m0_write};
  assign addr  = {m1_address, m0_address};
  assign wdata = {m1_writedata, m0_writedata};
  assign be    = {m1_byteenable, m0_byteenable};
  assign bc    = {m1_burstcount, m0_burstcount};

  for (genvar g = 0; g < 2; g++) begin : g_lane
    onchip_mem_port_arbiter_lane #(.BURST_W(BURST_W), .IDX(g[0])) u_lane (
      .read          (rd[g]),
      .write         (wr[g]),
      .burstcount    (bc[g]),
      .rd_vld        (rd_vld & ~reset),
      .rd_owner      (rd_owner),
      .req           (req[g]),
      .extra         (extra[g]),
      .readdatavalid (rdv[g])
    );
  end

  always_comb begin
    state_nx       = state;
    win            = (req[0] & req[1]) ? rr_ptr : req[1];
    accept         = 1'b0;
    step           = 1'b0;
    wait_n         = 2'b11;
    mem_address    = next_addr;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = wdata[owner];
    mem_byteenable = '1;
    if (!reset) begin
      case (state)
        IDLE: if (|req) begin
          // first beat goes out in the accept cycle; write wins over read
          accept         = 1'b1;
          wait_n[win]    = 1'b0;
          mem_address    = addr[win];
          mem_chipselect = 1'b1;
          mem_write      = wr[win];
          mem_writedata  = wdata[win];
          if (wr[win]) mem_byteenable = be[win];
          if (extra[win] != '0) state_nx = wr[win] ? WBURST : RBURST;
        end
        RBURST: begin
          mem_chipselect = 1'b1;
          step           = 1'b1;
          if (remaining == BURST_W'(1)) state_nx = IDLE;
        end
        WBURST: begin
          wait_n[owner] = 1'b0;
          if (wr[owner]) begin
            mem_chipselect = 1'b1;
            mem_write      = 1'b1;
            mem_byteenable = be[owner];
            step           = 1'b1;
            if (remaining == BURST_W'(1)) state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      owner     <= 1'b0;
      next_addr <= '0;
      remaining <= '0;
      rd_vld    <= 1'b0;
      rd_owner  <= 1'b0;
    end else begin
      state    <= state_nx;
      rd_vld   <= mem_chipselect & ~mem_write;
      rd_owner <= (state == IDLE) ? win : owner;
      if (accept) begin
        owner     <= win;
        rr_ptr    <= ~win;
        next_addr <= addr[win] + ADDR_W'(1);
        remaining <= extra[win];
      end else if (step) begin
        next_addr <= next_addr + ADDR_W'(1);
        remaining <= remaining - BURST_W'(1);
      end
    end
  end

  assign m0_waitrequest   = wait_n[0];
  assign m1_waitrequest   = wait_n[1];
  assign m0_readdatavalid = rdv[0];
  assign m1_readdatavalid = rdv[1];
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
endmodule

// File: tb/tb_onchip_mem_port_arbiter.sv
// Directed test-plan scenarios plus randomized two-master bursts checked against a
// transaction-level reference memory.
module tb_onchip_mem_port_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  rd = '0, wr = '0;
  logic [16:0] ad [2];
  logic [63:0] wd [2];
  logic [7:0]  be [2];
  logic [4:0]  bc [2];
  logic        m0_wq, m1_wq, m0_rv, m1_rv;
  logic [63:0] m0_rd, m1_rd;
  logic [16:0] mem_a;
  logic        mem_cs, mem_we;
  logic [63:0] mem_wd, q;
  logic [7:0]  mem_be;

  wire [1:0]       wq   = {m1_wq, m0_wq};
  wire [1:0]       rv   = {m1_rv, m0_rv};
  wire [1:0][63:0] rdat = {m1_rd, m0_rd};

  onchip_mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(ad[0]), .m0_read(rd[0]), .m0_write(wr[0]), .m0_writedata(wd[0]),
    .m0_byteenable(be[0]), .m0_burstcount(bc[0]), .m0_waitrequest(m0_wq),
    .m0_readdata(m0_rd), .m0_readdatavalid(m0_rv),
    .m1_address(ad[1]), .m1_read(rd[1]), .m1_write(wr[1]), .m1_writedata(wd[1]),
    .m1_byteenable(be[1]), .m1_burstcount(bc[1]), .m1_waitrequest(m1_wq),
    .m1_readdata(m1_rd), .m1_readdatavalid(m1_rv),
    .mem_address(mem_a), .mem_chipselect(mem_cs), .mem_write(mem_we),
    .mem_writedata(mem_wd), .mem_byteenable(mem_be), .mem_readdata(q)
  );

  int tests = 0, fails = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] init_val(input logic [16:0] a);
    if (a == 17'h10) return 64'h0123456789ABCDEF;
    return {32'hC0DE0000 ^ {15'd0, a}, 32'h5A5A5A5A + {15'd0, a}};
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n, input logic [7:0] e);
    logic [63:0] r = o;
    for (int b = 0; b < 8; b++) if (e[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [16:0] wrap(input logic [16:0] b, input int i);
    logic [16:0] r;
    r = b + 17'(i);
    return r;
  endfunction

  // memory: registered address, q valid the cycle after the read is presented
  logic [63:0] mem [131072];
  bit          wrt [131072];
  function automatic logic [63:0] rdmem(input logic [16:0] a);
    return wrt[a] ? mem[a] : init_val(a);
  endfunction
  always @(posedge clk) if (mem_cs) begin
    if (mem_we) begin
      mem[mem_a] <= merge(rdmem(mem_a), mem_wd, mem_be);
      wrt[mem_a] <= 1'b1;
    end
    q <= rdmem(mem_a);
  end

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  bit          wpat [6] = '{1, 1, 0, 0, 1, 1};
  logic [63:0] wdat [6] = '{64'd1, 64'd2, 64'd0, 64'd0, 64'd3, 64'd4};
  logic [16:0] wadr [6] = '{17'h100, 17'h101, 17'h0, 17'h0, 17'h102, 17'h103};

  // random-phase master state
  logic [63:0] refm [logic [16:0]];
  bit          busy [2], isw [2], acc [2];
  int          len [2], nb [2], nr [2];
  logic [16:0] base [2];

  initial begin
    logic [63:0] e;
    for (int m = 0; m < 2; m++) begin ad[m] = '0; wd[m] = '0; be[m] = '1; bc[m] = 5'd1; end
    rd[0] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wait", wq, 2'b11);
    chk("rst_rv", rv, 2'b00);
    chk("rst_cs", mem_cs, 0);
    @(posedge clk); #1;
    reset = 1'b0; rd = '0;
    @(negedge clk);
    chk("idle_cs", mem_cs, 0);
    chk("idle_we", mem_we, 0);
    chk("idle_rv", rv, 2'b00);
    nxt();

    // single m0 read
    rd[0] = 1; ad[0] = 17'h10; bc[0] = 1;
    @(negedge clk);
    chk("t1_wait", wq, 2'b10);
    chk("t1_addr", mem_a, 17'h10);
    chk("t1_cs", mem_cs, 1);
    chk("t1_we", mem_we, 0);
    nxt(); rd[0] = 0;
    @(negedge clk);
    chk("t1_rv", rv, 2'b01);
    chk("t1_data", rdat[0], 64'h0123456789ABCDEF);
    nxt();

    // m1 write burst of 4 with a two-cycle stall; m0 reads against it
    ad[1] = 17'h100; bc[1] = 4; be[1] = 8'hFF;
    for (int c = 0; c < 6; c++) begin
      wr[1] = wpat[c]; wd[1] = wdat[c];
      if (c >= 1) begin rd[0] = 1; ad[0] = 17'h10; bc[0] = 1; end
      @(negedge clk);
      chk("t2_m0_wait", wq[0], 1);
      chk("t2_cs", mem_cs, 64'(wpat[c]));
      if (wpat[c]) begin
        chk("t2_addr", mem_a, wadr[c]);
        chk("t2_m1_wait", wq[1], 0);
      end
      nxt();
    end
    wr[1] = 0;
    @(negedge clk);
    chk("t2_m0_after", wq, 2'b10);
    nxt(); rd[0] = 0;
    @(negedge clk);
    chk("t2_m0_rv", rv, 2'b01);
    for (int i = 0; i < 4; i++) chk("t2_memword", rdmem(17'(17'h100 + i)), 64'(i + 1));

    // lone m1 read: leaves m0 preferred next time
    nxt(); rd[1] = 1; ad[1] = 17'h100; bc[1] = 1;
    @(negedge clk);
    chk("t3_lone_wait", wq, 2'b01);
    nxt(); rd[1] = 0;
    @(negedge clk);
    chk("t3_lone_rv", rv, 2'b10);
    chk("t3_lone_data", rdat[1], 64'd1);
    nxt();

    // both masters issue single reads every cycle: grants alternate
    for (int k = 0; k <= 6; k++) begin
      rd = (k < 6) ? 2'b11 : 2'b00;
      ad[0] = 17'h10; ad[1] = 17'h100; bc[0] = 1; bc[1] = 1;
      @(negedge clk);
      if (k < 6) chk("t3_grant", wq, (k % 2 == 0) ? 2'b10 : 2'b01);
      if (k > 0) begin
        chk("t3_rv", rv, ((k - 1) % 2 == 0) ? 2'b01 : 2'b10);
        chk("t3_data", rdat[0], ((k - 1) % 2 == 0) ? 64'h0123456789ABCDEF : 64'd1);
      end
      nxt();
    end

    // 16-beat read wrapping the address space; m1 waits 16 cycles
    for (int i = 0; i <= 17; i++) begin
      if (i == 0) begin
        rd = 2'b11; ad[0] = 17'h1FFF8; bc[0] = 5'd16; ad[1] = 17'h100; bc[1] = 1;
      end
      if (i == 1) rd[0] = 0;
      if (i == 17) rd[1] = 0;
      @(negedge clk);
      if (i == 0) chk("t4_m0_acc", wq[0], 0);
      if (i <= 15) begin
        chk("t4_addr", mem_a, wrap(17'h1FFF8, i));
        chk("t4_cs", mem_cs, 1);
        chk("t4_m1_wait", wq[1], 1);
      end
      if (i == 16) begin
        chk("t4_m1_acc", wq[1], 0);
        chk("t4_m1_addr", mem_a, 17'h100);
      end
      if (i >= 1 && i <= 16) begin
        chk("t4_rv", rv, 2'b01);
        chk("t4_data", rdat[0], init_val(wrap(17'h1FFF8, i - 1)));
      end
      if (i == 17) chk("t4_m1_rv", rv, 2'b10);
      nxt();
    end

    // burstcount 0 write with partial byteenable
    wr[0] = 1; ad[0] = 17'h20; bc[0] = 0; be[0] = 8'h0F; wd[0] = 64'hAAAABBBBCCCCDDDD;
    @(negedge clk);
    chk("t5_wait", wq[0], 0);
    chk("t5_we", mem_we, 1);
    chk("t5_be", mem_be, 8'h0F);
    nxt(); wr[0] = 0; rd[1] = 1; ad[1] = 17'h100; bc[1] = 1;
    @(negedge clk);
    chk("t5_idle", wq[1], 0);
    nxt(); rd[1] = 0;
    e = init_val(17'h20);
    chk("t5_word", rdmem(17'h20), {e[63:32], 32'hCCCCDDDD});

    // reset in the 3rd cycle of an 8-beat read burst
    rd[0] = 1; ad[0] = 17'h0; bc[0] = 8;
    @(negedge clk);
    chk("t6_acc", wq[0], 0);
    nxt(); rd[0] = 0;
    nxt(); reset = 1;
    nxt(); reset = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t6_cs", mem_cs, 0);
      chk("t6_rv", rv, 2'b00);
      nxt();
    end
    rd = 2'b11; ad[0] = 17'h10; ad[1] = 17'h100; bc[0] = 1; bc[1] = 1;
    @(negedge clk);
    chk("t6_grant", wq, 2'b10);
    nxt(); rd = 2'b00;
    @(negedge clk);
    chk("t6_rv_after", rv, 2'b01);
    nxt(); nxt();

    // randomized bursts; m0 region straddles the address wrap, m1 region is disjoint
    for (int a = 0; a < 64; a++) begin
      refm[wrap(17'h1FFF0, a)] = rdmem(wrap(17'h1FFF0, a));
      refm[wrap(17'h100, a)]   = rdmem(wrap(17'h100, a));
    end
    for (int m = 0; m < 2; m++) begin busy[m] = 0; acc[m] = 0; end
    for (int c = 0; c < 3400; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (busy[m] && acc[m]) begin
          if (isw[m]) begin
            if (nb[m] == len[m]) begin busy[m] = 0; wr[m] = 0; end
            else begin wr[m] = ($urandom_range(0, 3) != 0); wd[m] = {$urandom, $urandom}; be[m] = 8'($urandom); end
          end else begin
            rd[m] = 0;
            if (nr[m] == len[m]) busy[m] = 0;
          end
        end
        if (!busy[m] && c < 3000 && $urandom_range(0, 2) == 0) begin
          int lr;
          lr = $urandom_range(0, 16);
          busy[m] = 1; acc[m] = 0; nb[m] = 0; nr[m] = 0;
          isw[m] = 1'($urandom_range(0, 1));
          len[m] = (lr == 0) ? 1 : lr;
          base[m] = (m == 0) ? wrap(17'h1FFF0, $urandom_range(0, 31)) : wrap(17'h100, $urandom_range(0, 31));
          rd[m] = !isw[m]; wr[m] = isw[m];
          ad[m] = base[m]; bc[m] = 5'(lr);
          wd[m] = {$urandom, $urandom}; be[m] = 8'($urandom);
        end
      end
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        logic [16:0] a;
        if (rv[m]) begin
          if (busy[m] && !isw[m] && acc[m] && nr[m] < len[m]) begin
            chk("rnd_rdata", rdat[m], refm[wrap(base[m], nr[m])]);
            nr[m]++;
          end else chk("rnd_stray_rv", 64'(rv[m]), 0);
        end
        if (!wq[m] && (rd[m] || wr[m])) begin
          if (!acc[m]) acc[m] = 1;
          if (isw[m] && wr[m]) begin
            a = wrap(base[m], nb[m]);
            refm[a] = merge(refm[a], wd[m], be[m]);
            nb[m]++;
          end
        end
      end
      nxt();
    end
    chk("rnd_drain0", 64'(busy[0]), 0);
    chk("rnd_drain1", 64'(busy[1]), 0);
    for (int a = 0; a < 64; a++) begin
      chk("rnd_mem0", rdmem(wrap(17'h1FFF0, a)), refm[wrap(17'h1FFF0, a)]);
      chk("rnd_mem1", rdmem(wrap(17'h100, a)), refm[wrap(17'h100, a)]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
